// File: rtl/fifo_stream_pkg.sv
// rtl/fifo_stream_pkg.sv - shared constants and helpers for the FIFO stream reader
// Contents:
//   MIN_READ_LATENCY / MAX_READ_LATENCY : legal FIFO read latency range
//   lvl_width(depth)                    : width of an occupancy counter for depth entries
//   read_latency_ok(lat)                : range check used at elaboration
package fifo_stream_pkg;

    localparam int MIN_READ_LATENCY = 1;
    localparam int MAX_READ_LATENCY = 3;

    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit read_latency_ok(input int lat);
        return (lat >= MIN_READ_LATENCY) && (lat <= MAX_READ_LATENCY);
    endfunction

endpackage

// File: rtl/fifo_stream_buf.sv
// rtl/fifo_stream_buf.sv - circular register buffer in front of the stream port
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   wr_en      : write wr_data at the write pointer
//   wr_data    : WIDTH-bit write word
//   rd_en      : pop the head entry (ignored when empty)
//   clr        : synchronous clear of pointers and occupancy
//   rd_data    : head entry, 0 when empty
//   level      : occupancy
module fifo_stream_buf
    import fifo_stream_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3,
    localparam int LVL_W = lvl_width(DEPTH),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             clr,
    output logic [WIDTH-1:0] rd_data,
    output logic [LVL_W-1:0] level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] cnt;
    logic             pop;

    // Depth is generally not a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop = rd_en && (cnt != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)   rd_ptr <= ptr_inc(rd_ptr);
            case ({wr_en, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && !clr) mem[wr_ptr] <= wr_data;
    end

    // Gate with occupancy so stale entries never show on the stream port.
    assign rd_data = (cnt != '0) ? mem[rd_ptr] : '0;
    assign level   = cnt;

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drives a FIFO read strobe and re-times words onto a valid/ready stream
// Optional feature macro: FIFO_STREAM_READER_VALID_CHECK_EN (tail-bit vs fifo_valid checker)
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   fifo_empty     : FIFO empty flag
//   fifo_dout      : FIFO read data, valid READ_LATENCY cycles after fifo_shift_out
//   fifo_valid     : FIFO data_valid, only observed by the checker build
//   fifo_shift_out : FIFO read enable
//   flush          : drop buffered and in-flight words
//   m_data/m_valid/m_ready : output stream
//   buf_level      : buffer occupancy
//   protocol_err   : sticky read-pipeline mismatch flag
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1,
    localparam int BUF_DEPTH   = READ_LATENCY + 2,
    localparam int LVL_W       = lvl_width(BUF_DEPTH)
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_valid,
    output logic                  fifo_shift_out,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [LVL_W-1:0]      buf_level,
    output logic                  protocol_err
);

    generate
        if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
            $error("fifo_stream_reader: READ_LATENCY out of range");
        end
    endgenerate

    logic [READ_LATENCY-1:0] pipe;
    logic [READ_LATENCY-1:0] pipe_next;
    logic [LVL_W:0]          credit_used;
    logic                    tail;
    logic                    issue;
    logic                    pop;

    // Credits cover both stored words and words already requested, so an
    // arriving word always finds a free slot regardless of m_ready.
    always_comb begin
        credit_used = {1'b0, buf_level};
        for (int i = 0; i < READ_LATENCY; i++) begin
            credit_used = credit_used + {{LVL_W{1'b0}}, pipe[i]};
        end
    end

    assign issue = rst_n && !fifo_empty && !flush &&
                   (credit_used < (LVL_W + 1)'(BUF_DEPTH));
    assign fifo_shift_out = issue;

    always_comb begin
        pipe_next    = '0;
        pipe_next[0] = issue;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_next[i] = pipe[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     pipe <= '0;
        else if (flush) pipe <= '0;
        else            pipe <= pipe_next;
    end

    assign tail    = pipe[READ_LATENCY-1];
    assign m_valid = (buf_level != '0);
    assign pop     = m_valid && m_ready;

    fifo_stream_buf #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (tail && !flush),
        .wr_data (fifo_dout),
        .rd_en   (pop),
        .clr     (flush),
        .rd_data (m_data),
        .level   (buf_level)
    );

`ifdef FIFO_STREAM_READER_VALID_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  err_q <= 1'b0;
        else if (tail != fifo_valid) err_q <= 1'b1;
    end

    assign protocol_err = err_q;
`else
    logic unused_fifo_valid;

    assign unused_fifo_valid = fifo_valid;
    assign protocol_err      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

    localparam int RL    = 3;
    localparam int DEPTH = RL + 2;
    localparam int LW    = $clog2(DEPTH + 1);

`ifdef FIFO_STREAM_READER_VALID_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_empty;
    logic [31:0]   fifo_dout;
    logic          fifo_valid;
    logic          fifo_shift_out;
    logic          flush;
    logic [31:0]   m_data;
    logic          m_valid;
    logic          m_ready;
    logic [LW-1:0] buf_level;
    logic          protocol_err;
    logic          valid_kill;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    fifo_stream_reader #(
        .DATA_WIDTH   (32),
        .READ_LATENCY (RL)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fifo_empty     (fifo_empty),
        .fifo_dout      (fifo_dout),
        .fifo_valid     (fifo_valid),
        .fifo_shift_out (fifo_shift_out),
        .flush          (flush),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .buf_level      (buf_level),
        .protocol_err   (protocol_err)
    );

    // FIFO model with fixed read latency RL
    logic [31:0] fifo_mem [0:511];
    int          wr_cnt = 0;
    int          rd_idx = 0;
    int          underflow = 0;
    logic [31:0] st_d [RL];
    logic        st_v [RL];

    assign fifo_empty = (rd_idx == wr_cnt);
    assign fifo_dout  = st_d[RL-1];
    assign fifo_valid = st_v[RL-1] && !valid_kill;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx <= wr_cnt;
            for (int i = 0; i < RL; i++) begin
                st_v[i] <= 1'b0;
                st_d[i] <= '0;
            end
        end else begin
            if (fifo_shift_out) begin
                if (fifo_empty) underflow <= underflow + 1;
                else            rd_idx    <= rd_idx + 1;
            end
            st_v[0] <= fifo_shift_out && !fifo_empty;
            st_d[0] <= fifo_mem[rd_idx];
            for (int i = 1; i < RL; i++) begin
                st_v[i] <= st_v[i-1];
                st_d[i] <= st_d[i-1];
            end
        end
    end

    task automatic push(input logic [31:0] w);
        fifo_mem[wr_cnt] = w;
        wr_cnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Consume n words expecting base, base+1, ...; optionally stall m_ready
    // for stall_len cycles once stall_at words have been taken.
    task automatic stream_run(input int n, input logic [31:0] base, input int stall_at,
                              input int stall_len, input string tag);
        int          got = 0;
        int          cyc = 0;
        int          gaps = 0;
        int          peak = 0;
        int          hold_bad = 0;
        int          credit_bad = 0;
        int          after_stall = 0;
        int          stall_left;
        bit          started = 0;
        logic [31:0] held = '0;
        stall_left = stall_len;
        while (got < n && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            m_ready = !(got == stall_at && stall_left > 0);
            #1;
            if (!m_ready) begin
                if (stall_left == stall_len) held = m_data;
                else if (m_data !== held || !m_valid) hold_bad++;
                if (int'(buf_level) > peak) peak = int'(buf_level);
                if (int'(buf_level) == DEPTH && fifo_shift_out) credit_bad++;
                stall_left--;
                if (stall_left == 0) after_stall = 1;
            end else begin
                if (after_stall == 1) begin
                    chk({tag, "_resume_wait"}, fifo_shift_out, 1'b0);
                    after_stall = 2;
                end else if (after_stall == 2) begin
                    chk({tag, "_resume_issue"}, fifo_shift_out, 1'b1);
                    after_stall = 3;
                end
                if (m_valid) begin
                    chk({tag, "_data"}, m_data, base + got);
                    got++;
                    started = 1;
                end else if (started) begin
                    gaps++;
                end
            end
        end
        chk({tag, "_count"}, got, n);
        chk({tag, "_gaps"}, gaps, 0);
        if (stall_len > 0) begin
            chk({tag, "_peak"}, peak, DEPTH);
            chk({tag, "_hold"}, hold_bad, 0);
            chk({tag, "_credit"}, credit_bad, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit found;
        rst_n      = 1'b0;
        flush      = 1'b0;
        m_ready    = 1'b0;
        valid_kill = 1'b0;

        // Reset state, with a word present in the FIFO
        repeat (3) @(negedge clk);
        push(32'hDEAD_0000);
        #1;
        chk("rst_m_valid", m_valid, 1'b0);
        chk("rst_m_data", m_data, 32'h0);
        chk("rst_level", buf_level, 0);
        chk("rst_shift_out", fifo_shift_out, 1'b0);
        chk("rst_err", protocol_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // First-word latency
        m_ready = 1'b1;
        repeat (2) @(negedge clk);
        push(32'hA5A5_0001);
        #1;
        chk("lat_issue", fifo_shift_out, 1'b1);
        for (int k = 1; k <= RL + 2; k++) begin
            @(negedge clk);
            #1;
            if (k == 1)      chk("lat_single_pulse", fifo_shift_out, 1'b0);
            if (k == RL)     chk("lat_not_early", m_valid, 1'b0);
            if (k == RL + 1) begin
                chk("lat_valid", m_valid, 1'b1);
                chk("lat_data", m_data, 32'hA5A5_0001);
            end
            if (k == RL + 2) chk("lat_after", m_valid, 1'b0);
        end

        // Sustained streaming
        for (int i = 0; i < 64; i++) push(i);
        stream_run(64, 32'd0, -1, 0, "stream");

        // Backpressure mid-stream
        for (int i = 0; i < 64; i++) push(i);
        stream_run(64, 32'd0, 20, 10, "bp");

        // Flush with level 3 and two words in flight
        @(negedge clk);
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) push(32'h100 + i);
        found = 0;
        for (int k = 0; k < 50 && !found; k++) begin
            #1;
            if (int'(buf_level) == 3) found = 1;
            else @(negedge clk);
        end
        chk("flush_reached_level3", found, 1'b1);
        flush = 1'b1;
        #1;
        chk("flush_no_issue", fifo_shift_out, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_level", buf_level, 0);
        chk("flush_m_valid", m_valid, 1'b0);
        stream_run(5, 32'h105, -1, 0, "post_flush");

        // Read-pipeline checker
        @(negedge clk);
        valid_kill = 1'b1;
        push(32'h0C0C_0001);
        repeat (RL + 2) @(negedge clk);
        valid_kill = 1'b0;
        #1;
        chk("err_set", protocol_err, EXP_ERR);
        repeat (3) @(negedge clk);
        #1;
        chk("err_held", protocol_err, EXP_ERR);

        // Reset mid-operation
        @(negedge clk);
        for (int i = 0; i < 20; i++) push(32'h200 + i);
        m_ready = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        chk("mid_active", m_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", m_valid, 1'b0);
        chk("mid_rst_m_data", m_data, 32'h0);
        chk("mid_rst_level", buf_level, 0);
        chk("mid_rst_shift_out", fifo_shift_out, 1'b0);
        chk("mid_rst_err", protocol_err, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("post_rst_quiet_valid", m_valid, 1'b0);
            chk("post_rst_quiet_data", m_data, 32'h0);
            @(negedge clk);
        end
        push(32'h0000_BEEF);
        for (int k = 1; k <= RL + 1; k++) begin
            @(negedge clk);
            #1;
            if (k == RL + 1) begin
                chk("post_rst_valid", m_valid, 1'b1);
                chk("post_rst_data", m_data, 32'h0000_BEEF);
            end
        end

        @(negedge clk);
        chk("no_underflow", underflow, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
